// File: rtl/motor_drive_if.sv
// Steering command in, H-bridge PWM/direction pins and status out.
interface motor_drive_if;
    logic [1:0] state;
    logic       left_pwm;
    logic       right_pwm;
    logic [1:0] left_dir;
    logic [1:0] right_dir;
    logic [1:0] active_cmd;
    logic       ramping;

    modport master (
        output state,
        input  left_pwm, right_pwm, left_dir, right_dir, active_cmd, ramping
    );

    modport slave (
        input  state,
        output left_pwm, right_pwm, left_dir, right_dir, active_cmd, ramping
    );
endinterface

// File: rtl/motor_drive.sv
// Glitch-filtered steering command -> left/right PWM + H-bridge direction with brake on stop.
// Optional soft-start duty ramp: define MOTOR_SOFTSTART_EN.
module motor_drive #(
    parameter int PWM_BITS     = 10,
    parameter int CMD_STABLE   = 4,
    parameter int FWD_DUTY     = 768,
    parameter int TURN_FAST    = 768,
    parameter int TURN_SLOW    = 256,
    parameter int RAMP_STEP    = 64,
    parameter int BRAKE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         reset,
    motor_drive_if.slave bus
);
    localparam int DW = PWM_BITS + 1;
    localparam int SW = $clog2(CMD_STABLE + 1);
    localparam int TW = $clog2(BRAKE_CYCLES + 1);

    localparam logic [DW-1:0] D_FWD  = DW'(FWD_DUTY);
    localparam logic [DW-1:0] D_FAST = DW'(TURN_FAST);
    localparam logic [DW-1:0] D_SLOW = DW'(TURN_SLOW);
    localparam logic [SW-1:0] STABLE_N = SW'(CMD_STABLE);
    localparam logic [TW-1:0] BRAKE_N  = TW'(BRAKE_CYCLES);

    // Without soft-start the step spans the whole duty range, so one wrap lands on the target.
`ifdef MOTOR_SOFTSTART_EN
    localparam bit SOFTSTART = 1'b1;
`else
    localparam bit SOFTSTART = 1'b0;
`endif
    localparam logic [DW-1:0] D_STEP = SOFTSTART ? DW'(RAMP_STEP) : '1;

    typedef enum logic [1:0] {STOP, RUN, BRAKE} mode_t;

    mode_t               mode, mode_nx;
    logic [1:0]          sample, cand, cand_nx, active;
    logic [SW-1:0]       count, count_nx;
    logic                accept;
    logic [PWM_BITS-1:0] cnt;
    logic                wrap;
    logic [DW-1:0]       duty_l, duty_r, duty_l_nx, duty_r_nx, tgt_l, tgt_r;
    logic [TW-1:0]       timer, timer_nx;
    logic                force_zero;
    logic                pwm_l, pwm_r;
    logic [1:0]          dir;

    function automatic logic [DW-1:0] ramp(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
        if (cur < tgt) return (tgt - cur > D_STEP) ? cur + D_STEP : tgt;
        if (cur > tgt) return (cur - tgt > D_STEP) ? cur - D_STEP : tgt;
        return cur;
    endfunction

    // Acceptance fires on the same edge the run of identical samples reaches CMD_STABLE.
    always_comb begin
        cand_nx  = cand;
        count_nx = count;
        if (sample != cand) begin
            cand_nx  = sample;
            count_nx = SW'(1);
        end else if (count < STABLE_N) begin
            count_nx = count + SW'(1);
        end
        accept = (count_nx == STABLE_N) && (cand_nx != active);
    end

    always_comb begin
        tgt_l = '0;
        tgt_r = '0;
        case (active)
            2'b11:   begin tgt_l = D_FWD;  tgt_r = D_FWD;  end
            2'b01:   begin tgt_l = D_SLOW; tgt_r = D_FAST; end
            2'b10:   begin tgt_l = D_FAST; tgt_r = D_SLOW; end
            default: ;
        endcase
    end

    always_comb begin
        mode_nx    = mode;
        timer_nx   = timer;
        force_zero = 1'b0;
        case (mode)
            STOP: if (accept && cand_nx != 2'b00) mode_nx = RUN;
            RUN: if (accept && cand_nx == 2'b00) begin
                mode_nx    = BRAKE;
                timer_nx   = BRAKE_N;
                force_zero = 1'b1;
            end
            BRAKE: begin
                if (accept) begin
                    mode_nx  = RUN;
                    timer_nx = '0;
                end else if (timer <= TW'(1)) begin
                    mode_nx  = STOP;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            default: mode_nx = STOP;
        endcase
    end

    assign wrap = (cnt == '1);

    always_comb begin
        duty_l_nx = duty_l;
        duty_r_nx = duty_r;
        if (force_zero) begin
            duty_l_nx = '0;
            duty_r_nx = '0;
        end else if (wrap) begin
            duty_l_nx = ramp(duty_l, tgt_l);
            duty_r_nx = ramp(duty_r, tgt_r);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= 2'b00;
            cand   <= 2'b00;
            count  <= '0;
            active <= 2'b00;
            mode   <= STOP;
            timer  <= '0;
            cnt    <= '0;
            duty_l <= '0;
            duty_r <= '0;
            pwm_l  <= 1'b0;
            pwm_r  <= 1'b0;
            dir    <= 2'b00;
        end else begin
            sample <= bus.state;
            cand   <= cand_nx;
            count  <= count_nx;
            if (accept) active <= cand_nx;
            mode   <= mode_nx;
            timer  <= timer_nx;
            cnt    <= cnt + PWM_BITS'(1);
            duty_l <= duty_l_nx;
            duty_r <= duty_r_nx;
            pwm_l  <= {1'b0, cnt} < duty_l;
            pwm_r  <= {1'b0, cnt} < duty_r;
            case (mode)
                RUN:     dir <= 2'b10;
                BRAKE:   dir <= 2'b11;
                default: dir <= 2'b00;
            endcase
        end
    end

    assign bus.left_pwm   = pwm_l;
    assign bus.right_pwm  = pwm_r;
    assign bus.left_dir   = dir;
    assign bus.right_dir  = dir;
    assign bus.active_cmd = active;
    assign bus.ramping    = (duty_l != tgt_l) || (duty_r != tgt_r);
endmodule

// File: tb/tb_motor_drive.sv
// Scripted test-plan scenarios then random command segments, every cycle checked against a behavioural model.
module tb_motor_drive;
    localparam int PB = 4, CS = 3, STEP = 4, FWD = 12, FAST = 12, SLOW = 4, BC = 5;
    localparam int PMAX = (1 << PB) - 1;
    localparam int M_STOP = 0, M_RUN = 1, M_BRAKE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    motor_drive_if bus();

    motor_drive #(
        .PWM_BITS(PB), .CMD_STABLE(CS), .FWD_DUTY(FWD), .TURN_FAST(FAST),
        .TURN_SLOW(SLOW), .RAMP_STEP(STEP), .BRAKE_CYCLES(BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model state
    int m_sq, m_act, m_mode, m_bt, m_cnt, m_al, m_ar, m_lp, m_rp, m_dir;
    int win[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tgt(input int cmd, input bit left);
        case (cmd)
            3:       return FWD;
            1:       return left ? SLOW : FAST;
            2:       return left ? FAST : SLOW;
            default: return 0;
        endcase
    endfunction

    function automatic int ramp(input int a, input int t);
`ifdef MOTOR_SOFTSTART_EN
        if (a < t) return (t - a > STEP) ? a + STEP : t;
        if (a > t) return (a - t > STEP) ? a - STEP : t;
        return a;
`else
        return t;
`endif
    endfunction

    task automatic model_step(input int st, input bit r);
        bit acc, same;
        int nc;
        if (r) begin
            m_sq = 0; m_act = 0; m_mode = M_STOP; m_bt = 0; m_cnt = 0;
            m_al = 0; m_ar = 0; m_lp = 0; m_rp = 0; m_dir = 0;
            win.delete();
            return;
        end
        // last CS registered samples all equal and different from the active command
        win.push_back(m_sq);
        if (win.size() > CS) void'(win.pop_front());
        acc = 1'b0;
        nc  = 0;
        if (win.size() == CS) begin
            same = 1'b1;
            foreach (win[i]) if (win[i] != win[0]) same = 1'b0;
            if (same && win[0] != m_act) begin
                acc = 1'b1;
                nc  = win[0];
            end
        end
        m_lp  = (m_cnt < m_al) ? 1 : 0;
        m_rp  = (m_cnt < m_ar) ? 1 : 0;
        m_dir = (m_mode == M_RUN) ? 2 : (m_mode == M_BRAKE) ? 3 : 0;
        if (m_cnt == PMAX) begin
            m_al = ramp(m_al, tgt(m_act, 1'b1));
            m_ar = ramp(m_ar, tgt(m_act, 1'b0));
        end
        if (acc) begin
            if (nc == 0) begin
                m_mode = M_BRAKE;
                m_bt   = BC;
                m_al   = 0;
                m_ar   = 0;
            end else begin
                m_mode = M_RUN;
            end
            m_act = nc;
        end else if (m_mode == M_BRAKE) begin
            if (m_bt <= 1) m_mode = M_STOP;
            else m_bt--;
        end
        m_sq  = st;
        m_cnt = (m_cnt + 1) % (PMAX + 1);
    endtask

    task automatic check_all();
        int rmp;
        rmp = (m_al != tgt(m_act, 1'b1) || m_ar != tgt(m_act, 1'b0)) ? 1 : 0;
        chk("left_pwm",   32'(bus.left_pwm),   m_lp);
        chk("right_pwm",  32'(bus.right_pwm),  m_rp);
        chk("left_dir",   32'(bus.left_dir),   m_dir);
        chk("right_dir",  32'(bus.right_dir),  m_dir);
        chk("active_cmd", 32'(bus.active_cmd), m_act);
        chk("ramping",    32'(bus.ramping),    rmp);
    endtask

    task automatic tick(input logic [1:0] st, input logic r);
        bus.state = st;
        reset     = r;
        @(posedge clk);
        model_step(int'(st), r);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic [1:0] st, input int n);
        for (int i = 0; i < n; i++) tick(st, 1'b0);
    endtask

    initial begin
        int nl, nr, nb, len;
        logic [1:0] c;
        bus.state = 2'b00;
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b1);
        chk("rst_active", 32'(bus.active_cmd), 0);
        chk("rst_dir", 32'(bus.left_dir), 0);

        // acceptance latency and dir lag
        hold(2'b11, 3);
        chk("acc_early", 32'(bus.active_cmd), 0);
        hold(2'b11, 1);
        chk("acc_lat", 32'(bus.active_cmd), 3);
        chk("dir_lag", 32'(bus.left_dir), 0);
        hold(2'b11, 1);
        chk("dir_run", 32'(bus.right_dir), 2);
        hold(2'b11, 60);
        chk("ramp_done", 32'(bus.ramping), 0);

        // short glitch is ignored
        hold(2'b01, 2);
        hold(2'b11, 10);
        chk("glitch", 32'(bus.active_cmd), 3);

        // turn left: duty 4 / 12 of 16
        hold(2'b01, 60);
        nl = 0;
        nr = 0;
        for (int i = 0; i < 16; i++) begin
            hold(2'b01, 1);
            nl += int'(bus.left_pwm);
            nr += int'(bus.right_pwm);
        end
        chk("lpwm_duty", nl, 4);
        chk("rpwm_duty", nr, 12);

        // stop and brake length
        hold(2'b11, 60);
        hold(2'b00, 4);
        chk("stop_acc", 32'(bus.active_cmd), 0);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            hold(2'b00, 1);
            if (i == 0) begin
                chk("stop_lpwm", 32'(bus.left_pwm), 0);
                chk("stop_rpwm", 32'(bus.right_pwm), 0);
            end
            if (bus.left_dir == 2'b11) nb++;
        end
        chk("brake_len", nb, 5);
        chk("brake_end", 32'(bus.left_dir), 0);

        // new command during brake aborts it
        hold(2'b11, 60);
        hold(2'b00, 4);
        hold(2'b10, 4);
        chk("abort_cmd", 32'(bus.active_cmd), 2);
        hold(2'b10, 1);
        chk("abort_dir", 32'(bus.left_dir), 2);

        // reset mid-ramp
        hold(2'b10, 6);
        tick(2'b10, 1'b1);
        chk("mrst_lpwm", 32'(bus.left_pwm), 0);
        chk("mrst_rpwm", 32'(bus.right_pwm), 0);
        chk("mrst_dir", 32'(bus.right_dir), 0);
        chk("mrst_act", 32'(bus.active_cmd), 0);
        chk("mrst_ramp", 32'(bus.ramping), 0);

        for (int s = 0; s < 40; s++) begin
            c   = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
            if ($urandom_range(0, 24) == 0) tick(c, 1'b1);
            hold(c, len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
